dtc_rx: RTL

- SRU-side receiver for the FEE DTC return link. It consumes the 4-bit-per-clock stream from the DTC input DDR capture and aligns to 16-bit words using the 0xBC50 sync word.
- It decodes three frame types: reply (0xF7F7), status (0xDCDC) and event (0x5C5C).
- Decoded register replies and FEE status go to the control path; event payload is written 32 bits at a time into the downstream event FIFO.

---
 rtl/dtc_rx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dtc_rx.sv
// dtc_rx: DTC return-link receiver aligning nibbles to 16-bit words and decoding reply, status and event frames
module dtc_rx #(
  parameter logic [15:0] SYNC_WORD = 16'hBC50,
  parameter int          LOCK_CNT  = 4,
  parameter int          ERR_MAX   = 8,
  parameter logic [15:0] FILL_WORD = 16'h8012,
  parameter logic [15:0] END_WORD  = 16'hC5D5
) (
  input  logic        rdoclk,
  input  logic        reset,
  input  logic [3:0]  rx_nib,
  output logic        locked,
  output logic        reply_valid,
  output logic [31:0] reply_addr,
  output logic [31:0] reply_data,
  output logic        status_valid,
  output logic        fee_flag,
  output logic        evt_wr,
  output logic [31:0] evt_data,
  output logic        evt_last,
  input  logic        evt_full,
  output logic        evt_ovf,
  output logic [15:0] event_cnt,
  output logic [15:0] err_cnt,
  input  logic        CntRst
);
  localparam logic [15:0] REPLY_HDR  = 16'hF7F7;
  localparam logic [15:0] STATUS_HDR = 16'hDCDC;
  localparam logic [15:0] EVENT_HDR  = 16'h5C5C;
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(ERR_MAX + 1);
  typedef enum logic [2:0] {SEARCH, IDLE, REPLY, STATUS, EVT_LO, EVT_HI, TRAIL} state_t;
  state_t st;
  logic [15:0] sr, lo;
  logic [47:0] tmp;
  logic [1:0] ph, lock_ph, idx;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bad;
  logic wr_pend, last_r, ws, w_sync, hdr, pair_fill, pair_end, err_inc, evt_inc;
  assign ws        = locked && ph == lock_ph;
  assign w_sync    = sr == SYNC_WORD;
  assign hdr       = sr == REPLY_HDR || sr == STATUS_HDR || sr == EVENT_HDR;
  assign pair_fill = sr == FILL_WORD && lo == FILL_WORD;
  assign pair_end  = sr == END_WORD && lo == END_WORD;
  assign err_inc   = ws && ((st == IDLE && !w_sync && !hdr) || (st == EVT_HI && pair_end) ||
                            (st == TRAIL && sr != END_WORD));
  assign evt_inc   = ws && ((st == EVT_HI && pair_end) || (st == TRAIL && sr == END_WORD && idx[0]));
  // The FIFO full flag is judged in the strobe cycle itself, so the write is gated here.
  assign evt_wr    = wr_pend && !evt_full;
  assign evt_last  = last_r && evt_wr;
  always_ff @(posedge rdoclk or negedge reset) begin
    if (!reset) begin
      st <= SEARCH;
      sr <= '0;
      lo <= '0;
      tmp <= '0;
      ph <= '0;
      lock_ph <= '0;
      idx <= '0;
      cnt <= '0;
      bad <= '0;
      locked <= 1'b0;
      reply_valid <= 1'b0;
      reply_addr <= '0;
      reply_data <= '0;
      status_valid <= 1'b0;
      fee_flag <= 1'b0;
      wr_pend <= 1'b0;
      last_r <= 1'b0;
      evt_data <= '0;
      evt_ovf <= 1'b0;
      event_cnt <= '0;
      err_cnt <= '0;
    end else begin
      sr <= {rx_nib, sr[15:4]};
      ph <= ph + 2'd1;
      reply_valid <= 1'b0;
      status_valid <= 1'b0;
      wr_pend <= 1'b0;
      if (CntRst) begin
        event_cnt <= '0;
        err_cnt <= '0;
        evt_ovf <= 1'b0;
      end else begin
        if (evt_inc) event_cnt <= event_cnt + 16'd1;
        if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (wr_pend && evt_full) evt_ovf <= 1'b1;
      end
      case (st)
        SEARCH:
          if (cnt == '0) begin
            if (w_sync) begin
              lock_ph <= ph;
              cnt <= CW'(1);
            end
          end else if (ph == lock_ph) begin
            if (!w_sync) cnt <= '0;
            else if (cnt == CW'(LOCK_CNT - 1)) begin
              cnt <= '0;
              locked <= 1'b1;
              st <= IDLE;
            end else cnt <= cnt + 1'b1;
          end
        IDLE:
          if (ws) begin
            if (w_sync || hdr) begin
              bad <= '0;
              idx <= '0;
              st <= sr == REPLY_HDR ? REPLY : sr == STATUS_HDR ? STATUS : sr == EVENT_HDR ? EVT_LO : IDLE;
            end else if (bad == BW'(ERR_MAX - 1)) begin
              bad <= '0;
              locked <= 1'b0;
              st <= SEARCH;
            end else bad <= bad + 1'b1;
          end
        REPLY:
          if (ws) begin
            tmp <= {tmp[31:0], sr};
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              reply_addr <= tmp[47:16];
              reply_data <= {tmp[15:0], sr};
              reply_valid <= 1'b1;
              st <= IDLE;
            end
          end
        STATUS:
          if (ws) begin
            fee_flag <= sr[0];
            status_valid <= 1'b1;
            st <= IDLE;
          end
        EVT_LO:
          if (ws) begin
            lo <= sr;
            st <= EVT_HI;
          end
        EVT_HI:
          if (ws) begin
            if (pair_fill) st <= EVT_LO;
            else if (pair_end) st <= IDLE;
            else begin
              wr_pend <= 1'b1;
              evt_data <= {sr, lo};
              last_r <= &sr[15:14];
              idx <= '0;
              st <= &sr[15:14] ? TRAIL : EVT_LO;
            end
          end
        TRAIL:
          if (ws) begin
            idx <= idx + 2'd1;
            if (sr != END_WORD || idx[0]) st <= IDLE;
          end
        default: st <= SEARCH;
      endcase
    end
  end
endmodule
